dii_packetizer: RTL and testbench

- Transmitter end of the DII debug-ring flit protocol: turns one parallel event (destination, type, payload words) into a serial DII packet.
- Drives a router's local input port. Sits between a debug module's event logic and its ring_router instance.
- Emits header flits (dest, src, flags) then payload flits, asserting last on the final flit.

---
 rtl/dii_pkg.sv | 11 +
 rtl/dii_packetizer.sv | 132 +++++++++++++
 tb/tb_dii_packetizer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/dii_pkg.sv
// Shared DII debug-ring types.
// dii_flit: one ring flit {valid, last, data[15:0]}.
package dii_pkg;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

endpackage

// File: rtl/dii_packetizer.sv
// DII packetizer: serialises one parallel debug event into a DII packet
// of flits DEST, SRC, FLAGS, then 0..MAX_PAYLOAD payload words.
// Ports: clk/rst (async, active-high); id = own ring address;
// event_* = request bundle with valid/ready handshake;
// debug_out/debug_out_ready = flit stream to the router local input.
module dii_packetizer
    import dii_pkg::*;
#(
    parameter int MAX_PAYLOAD = 8,
    localparam int LW = $clog2(MAX_PAYLOAD + 1),
    localparam int CW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [9:0]               id,
    input  logic [15:0]              event_dest,
    input  logic [1:0]               event_type,
    input  logic [3:0]               event_type_sub,
    input  logic [LW-1:0]            event_len,
    input  logic [16*MAX_PAYLOAD-1:0] event_payload,
    input  logic                     event_valid,
    output logic                     event_ready,
    output dii_flit                  debug_out,
    input  logic                     debug_out_ready
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DEST    = 3'd1;
    localparam logic [2:0] S_SRC     = 3'd2;
    localparam logic [2:0] S_FLAGS   = 3'd3;
    localparam logic [2:0] S_PAYLOAD = 3'd4;

    localparam logic [LW-1:0] MAX_LEN = LW'(MAX_PAYLOAD);

    logic [2:0]                   state_q, state_d;
    logic [15:0]                  dest_q, dest_d;
    logic [9:0]                   id_q, id_d;
    logic [1:0]                   type_q, type_d;
    logic [3:0]                   sub_q, sub_d;
    logic [LW-1:0]                len_q, len_d;
    logic [MAX_PAYLOAD-1:0][15:0] payload_q, payload_d;
    logic [CW-1:0]                cnt_q, cnt_d;

    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        id_d        = id_q;
        type_d      = type_q;
        sub_d       = sub_q;
        len_d       = len_q;
        payload_d   = payload_q;
        cnt_d       = cnt_q;
        event_ready = 1'b0;
        debug_out   = '0;

        case (state_q)
            S_IDLE: begin
                event_ready = 1'b1;
                if (event_valid) begin
                    dest_d    = event_dest;
                    id_d      = id;
                    type_d    = event_type;
                    sub_d     = event_type_sub;
                    // Oversized requests are truncated so the word
                    // counter can never run past the capture buffer.
                    len_d     = (event_len > MAX_LEN) ? MAX_LEN : event_len;
                    payload_d = event_payload;
                    cnt_d     = '0;
                    state_d   = S_DEST;
                end
            end
            S_DEST: begin
                debug_out.valid = 1'b1;
                debug_out.data  = dest_q;
                if (debug_out_ready) state_d = S_SRC;
            end
            S_SRC: begin
                debug_out.valid = 1'b1;
                debug_out.data  = {6'b0, id_q};
                if (debug_out_ready) state_d = S_FLAGS;
            end
            S_FLAGS: begin
                debug_out.valid = 1'b1;
                debug_out.last  = (len_q == '0);
                debug_out.data  = {type_q, sub_q, 10'b0};
                if (debug_out_ready) begin
                    if (debug_out.last) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                debug_out.valid = 1'b1;
                debug_out.last  = (LW'(cnt_q) == len_q - LW'(1));
                debug_out.data  = payload_q[cnt_q];
                if (debug_out_ready) begin
                    if (debug_out.last) state_d = S_IDLE;
                    else                cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            dest_q    <= '0;
            id_q      <= '0;
            type_q    <= '0;
            sub_q     <= '0;
            len_q     <= '0;
            payload_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            dest_q    <= dest_d;
            id_q      <= id_d;
            type_q    <= type_d;
            sub_q     <= sub_d;
            len_q     <= len_d;
            payload_q <= payload_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dii_packetizer.sv
// Directed bench for dii_packetizer (MAX_PAYLOAD = 8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dii_packetizer;
    import dii_pkg::*;

    localparam int MAXP = 8;
    localparam int LW   = $clog2(MAXP + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [9:0]           id;
    logic [15:0]          event_dest;
    logic [1:0]           event_type;
    logic [3:0]           event_type_sub;
    logic [LW-1:0]        event_len;
    logic [16*MAXP-1:0]   event_payload;
    logic                 event_valid;
    logic                 event_ready;
    dii_flit              debug_out;
    logic                 debug_out_ready;

    int checks = 0;
    int errs   = 0;

    dii_packetizer #(.MAX_PAYLOAD(MAXP)) dut (
        .clk             (clk),
        .rst             (rst),
        .id              (id),
        .event_dest      (event_dest),
        .event_type      (event_type),
        .event_type_sub  (event_type_sub),
        .event_len       (event_len),
        .event_payload   (event_payload),
        .event_valid     (event_valid),
        .event_ready     (event_ready),
        .debug_out       (debug_out),
        .debug_out_ready (debug_out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fl(input logic l, input logic [15:0] d);
        return {14'b0, 1'b1, l, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt_flit(input string tag, input logic [15:0] d,
                            input logic l);
        @(negedge clk);
        chk(tag, {14'b0, debug_out}, fl(l, d));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_out"}, {14'b0, debug_out}, 32'h0);
        chk({tag, "_rdy"}, {31'b0, event_ready}, 32'h1);
    endtask

    task automatic set_event(input logic [15:0] d, input logic [9:0] i,
                             input logic [1:0] t, input logic [3:0] s,
                             input logic [LW-1:0] n,
                             input logic [15:0] base);
        event_dest     = d;
        id             = i;
        event_type     = t;
        event_type_sub = s;
        event_len      = n;
        for (int k = 0; k < MAXP; k++)
            event_payload[16*k +: 16] = base + 16'(k);
        event_valid    = 1'b1;
    endtask

    logic [31:0] exp3 [0:10];
    int          idx;
    int          budget;
    logic        r;

    initial begin
        rst             = 1'b1;
        id              = '0;
        event_dest      = '0;
        event_type      = '0;
        event_type_sub  = '0;
        event_len       = '0;
        event_payload   = '0;
        event_valid     = 1'b0;
        debug_out_ready = 1'b1;

        // reset state
        @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        // basic len=2 packet
        set_event(16'h0003, 10'h005, 2'd2, 4'd1, 4'd2, 16'h0);
        event_payload[15:0]  = 16'h1234;
        event_payload[31:16] = 16'hBEEF;
        chk("t1_acc_rdy", {31'b0, event_ready}, 32'h1);
        nxt_flit("t1_dest", 16'h0003, 1'b0);
        event_valid = 1'b0;
        chk("t1_busy_rdy", {31'b0, event_ready}, 32'h0);
        nxt_flit("t1_src", 16'h0005, 1'b0);
        nxt_flit("t1_flags", 16'h8400, 1'b0);
        nxt_flit("t1_w0", 16'h1234, 1'b0);
        nxt_flit("t1_w1", 16'hBEEF, 1'b1);
        @(negedge clk);
        chk_idle("t1_end");

        // zero-length packet
        set_event(16'h0001, 10'h005, 2'd1, 4'd0, 4'd0, 16'h0);
        nxt_flit("t2_dest", 16'h0001, 1'b0);
        event_valid = 1'b0;
        nxt_flit("t2_src", 16'h0005, 1'b0);
        nxt_flit("t2_flags", 16'h4000, 1'b1);
        @(negedge clk);
        chk_idle("t2_end");

        // len=8 under random backpressure
        set_event(16'h00AB, 10'h155, 2'd1, 4'd3, 4'd8, 16'hA000);
        exp3[0] = fl(1'b0, 16'h00AB);
        exp3[1] = fl(1'b0, 16'h0155);
        exp3[2] = fl(1'b0, 16'h4C00);
        for (int k = 0; k < 8; k++)
            exp3[3+k] = fl(k == 7, 16'hA000 + 16'(k));
        @(negedge clk);
        event_valid = 1'b0;
        idx    = 0;
        budget = 0;
        while (idx < 11 && budget < 300) begin
            chk($sformatf("t3_flit%0d", idx), {14'b0, debug_out}, exp3[idx]);
            r = 1'($urandom_range(0, 1));
            debug_out_ready = r;
            if (r) idx++;
            @(negedge clk);
            budget++;
        end
        chk("t3_done", idx, 32'd11);
        debug_out_ready = 1'b1;
        chk_idle("t3_end");

        // oversize length clamps; inputs changed mid-packet are ignored
        set_event(16'h1234, 10'h3FF, 2'd3, 4'hF, 4'd15, 16'hC000);
        nxt_flit("t4_dest", 16'h1234, 1'b0);
        event_valid    = 1'b0;
        event_dest     = 16'hFFFF;
        id             = 10'h000;
        event_type     = 2'd0;
        event_type_sub = 4'd0;
        event_len      = 4'd1;
        event_payload  = '0;
        nxt_flit("t4_src", 16'h03FF, 1'b0);
        nxt_flit("t4_flags", 16'hFC00, 1'b0);
        for (int k = 0; k < 8; k++)
            nxt_flit($sformatf("t4_w%0d", k), 16'hC000 + 16'(k), k == 7);
        @(negedge clk);
        chk_idle("t4_end");

        // back-to-back events with valid held high
        set_event(16'h0010, 10'h005, 2'd0, 4'd2, 4'd1, 16'h1111);
        chk("t5_acc_rdy", {31'b0, event_ready}, 32'h1);
        nxt_flit("t5a_dest", 16'h0010, 1'b0);
        nxt_flit("t5a_src", 16'h0005, 1'b0);
        nxt_flit("t5a_flags", 16'h0800, 1'b0);
        nxt_flit("t5a_w0", 16'h1111, 1'b1);
        @(negedge clk);
        chk_idle("t5_gap");
        event_dest    = 16'h0020;
        event_payload[15:0] = 16'h2222;
        nxt_flit("t5b_dest", 16'h0020, 1'b0);
        event_valid = 1'b0;
        nxt_flit("t5b_src", 16'h0005, 1'b0);
        nxt_flit("t5b_flags", 16'h0800, 1'b0);
        nxt_flit("t5b_w0", 16'h2222, 1'b1);
        @(negedge clk);
        chk_idle("t5_end");

        // reset in the middle of a payload
        set_event(16'h0030, 10'h007, 2'd2, 4'd0, 4'd4, 16'hD000);
        nxt_flit("t6_dest", 16'h0030, 1'b0);
        event_valid = 1'b0;
        nxt_flit("t6_src", 16'h0007, 1'b0);
        nxt_flit("t6_flags", 16'h8000, 1'b0);
        nxt_flit("t6_w0", 16'hD000, 1'b0);
        nxt_flit("t6_w1", 16'hD001, 1'b0);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", {31'b0, debug_out.valid}, 32'h0);
        chk("t6_rst_rdy", {31'b0, event_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        chk_idle("t6_post_rst");
        set_event(16'h0040, 10'h009, 2'd1, 4'd1, 4'd1, 16'hE000);
        nxt_flit("t6n_dest", 16'h0040, 1'b0);
        event_valid = 1'b0;
        nxt_flit("t6n_src", 16'h0009, 1'b0);
        nxt_flit("t6n_flags", 16'h4400, 1'b0);
        nxt_flit("t6n_w0", 16'hE000, 1'b1);
        @(negedge clk);
        chk_idle("t6_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end

endmodule
